// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: converts 256-bit cache line requests into 4-beat 64-bit memory bursts.
// Reads assemble the fill line beat by beat (beat 0 at the lowest address). Writes stream the
// latched write-back line out one beat per memory strobe.
// Optional feature macro: CACHELINE_ADAPTOR_TIMEOUT_EN aborts a burst after TIMEOUT cycles
// without a memory strobe and flags the abort on err_o together with resp_o.
module cacheline_adaptor #(
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_burst  = 64,
  parameter int unsigned s_offset = 5,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [s_line-1:0]  line_i,
  output logic [s_line-1:0]  line_o,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  output logic               resp_o,
  output logic               err_o,
  input  logic [s_burst-1:0] burst_i,
  output logic [s_burst-1:0] burst_o,
  output logic [31:0]        address_o,
  output logic               read_o,
  output logic               write_o,
  input  logic               resp_i
);

  localparam int unsigned     Beats    = s_line / s_burst;
  localparam int unsigned     CntW     = (Beats > 1) ? $clog2(Beats) : 1;
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);
  localparam logic [31:0]     AddrMask = ~((32'd1 << s_offset) - 32'd1);

  typedef enum logic [2:0] {
    StIdle,
    StRdBurst,
    StRdDone,
    StWrBurst,
    StWrDone
  } state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  // Write-back line and fill line are kept apart so a write never disturbs line_o.
  logic [s_line-1:0] wbuf_q, wbuf_d;
  logic [s_line-1:0] fill_q, fill_d;

`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
  logic [15:0] wait_q, wait_d;
  logic        err_q, err_d;
`else
  // TIMEOUT only matters when the abort feature is built in.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // State, beat counter, latched address and line buffers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      addr_q  <= '0;
      wbuf_q  <= '0;
      fill_q  <= '0;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      wait_q  <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wbuf_q  <= wbuf_d;
      fill_q  <= fill_d;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
      wait_q  <= wait_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state logic: request acceptance, beat handling and burst completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wbuf_d  = wbuf_q;
    fill_d  = fill_q;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    wait_d  = wait_q;
    err_d   = err_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Write wins a tie; a still-held read is picked up on the next return to idle.
        if (write_i) begin
          addr_d  = address_i & AddrMask;
          wbuf_d  = line_i;
          cnt_d   = '0;
          state_d = StWrBurst;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          wait_d  = '0;
          err_d   = 1'b0;
`endif
        end else if (read_i) begin
          addr_d  = address_i & AddrMask;
          cnt_d   = '0;
          state_d = StRdBurst;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          wait_d  = '0;
          err_d   = 1'b0;
`endif
        end
      end

      StRdBurst: begin
        if (resp_i) begin
          fill_d[s_burst*32'(cnt_q) +: s_burst] = burst_i;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastBeat) begin
            state_d = StRdDone;
          end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          wait_d = '0;
        end else if (wait_q >= 16'(TIMEOUT)) begin
          state_d = StRdDone;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
`endif
        end
      end

      StWrBurst: begin
        if (resp_i) begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == LastBeat) begin
            state_d = StWrDone;
          end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
          wait_d = '0;
        end else if (wait_q >= 16'(TIMEOUT)) begin
          state_d = StWrDone;
          err_d   = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
`endif
        end
      end

      StRdDone, StWrDone: begin
        state_d = StIdle;
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
        err_d   = 1'b0;
`endif
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Memory-side and cache-side outputs decoded from the current state.
  always_comb begin
    read_o    = (state_q == StRdBurst);
    write_o   = (state_q == StWrBurst);
    resp_o    = (state_q == StRdDone) || (state_q == StWrDone);
    address_o = addr_q;
    line_o    = fill_q;
    burst_o   = '0;
    if (state_q == StWrBurst) begin
      burst_o = wbuf_q[s_burst*32'(cnt_q) +: s_burst];
    end
`ifdef CACHELINE_ADAPTOR_TIMEOUT_EN
    err_o = resp_o & err_q;
`else
    err_o = 1'b0;
`endif
  end

endmodule
